// File: rtl/lbp_pkg.sv
// Shared geometry, FSM encoding and border classification for the LBP host.
package lbp_pkg;

    localparam int IMG_W = 128;
    localparam int IMG_H = 128;
    localparam int AW    = 14;
    localparam int PIX_W = 8;
    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = AW - COL_W;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SERVE = 2'd1,
        DUMP  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // A pixel on the outermost ring has no full 3x3 neighbourhood.
    function automatic logic is_border(input logic [AW-1:0] addr);
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
        row = addr[AW-1:COL_W];
        col = addr[COL_W-1:0];
        return (row == {ROW_W{1'b0}}) || (row == ROW_W'(IMG_H - 1)) ||
               (col == {COL_W{1'b0}}) || (col == COL_W'(IMG_W - 1));
    endfunction

endpackage

// File: rtl/lbp_host_ram.sv
// Single write port, asynchronous read port storage array; contents are never reset.
module lbp_host_ram #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem_r [0:(1<<ADDR_W)-1];

    // Synchronous write
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/lbp_host.sv
// Host side of the LBP engine memory interface: image load, zero-latency gray reads,
// result capture and a valid/ready dump of the final LBP image.
module lbp_host
    import lbp_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             ld_valid,
    input  logic [PIX_W-1:0] ld_data,
    output logic             ld_ready,
    output logic             gray_ready,
    input  logic             gray_req,
    input  logic [AW-1:0]    gray_addr,
    output logic [PIX_W-1:0] gray_data,
    input  logic             lbp_valid,
    input  logic [AW-1:0]    lbp_addr,
    input  logic [PIX_W-1:0] lbp_data,
    input  logic             finish,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AW-1:0]    out_addr,
    output logic [PIX_W-1:0] out_data,
    output logic [AW-1:0]    wr_cnt,
    output logic             proto_err,
    output logic             done
);

    localparam logic [AW-1:0]    ADDR_ZERO = {AW{1'b0}};
    localparam logic [AW-1:0]    ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [AW-1:0]    ADDR_LAST = {AW{1'b1}};
    localparam logic [PIX_W-1:0] PIX_ZERO  = {PIX_W{1'b0}};

    state_t           state_r;
    state_t           state_nx_s;
    logic [AW-1:0]    ld_ptr_r;
    logic             gray_ready_r;
    logic             out_valid_r;
    logic [AW-1:0]    out_addr_r;
    logic [PIX_W-1:0] out_data_r;
    logic [AW-1:0]    wr_cnt_r;
    logic             proto_err_r;
    logic             done_r;

    logic             ld_acc_s;
    logic             ld_last_s;
    logic             res_we_s;
    logic             lbp_bad_s;
    logic             beat_acc_s;
    logic             dump_last_s;
    logic             fetch_s;
    logic [AW-1:0]    fetch_addr_s;
    logic [AW-1:0]    gray_raddr_s;
    logic [PIX_W-1:0] gray_rd_s;
    logic [PIX_W-1:0] res_rd_s;

    assign ld_acc_s     = ld_valid && (state_r == LOAD);
    assign ld_last_s    = (ld_ptr_r == ADDR_LAST);
    assign res_we_s     = (state_r == SERVE) && lbp_valid && !is_border(lbp_addr);
    assign lbp_bad_s    = (state_r == SERVE) && lbp_valid && is_border(lbp_addr);
    assign beat_acc_s   = (state_r == DUMP) && out_valid_r && out_ready;
    assign dump_last_s  = beat_acc_s && (out_addr_r == ADDR_LAST);
    // out_valid is low inside DUMP only on its first cycle, which primes address 0.
    assign fetch_s      = (state_r == DUMP) && (!out_valid_r || (beat_acc_s && !dump_last_s));
    assign fetch_addr_s = out_valid_r ? (out_addr_r + ADDR_ONE) : ADDR_ZERO;
    assign gray_raddr_s = gray_req ? gray_addr : ADDR_ZERO;

    lbp_host_ram #(.ADDR_W(AW), .DATA_W(PIX_W)) u_gray_mem (
        .clk   (clk),
        .we    (ld_acc_s),
        .waddr (ld_ptr_r),
        .wdata (ld_data),
        .raddr (gray_raddr_s),
        .rdata (gray_rd_s)
    );

    lbp_host_ram #(.ADDR_W(AW), .DATA_W(PIX_W)) u_res_mem (
        .clk   (clk),
        .we    (res_we_s),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .raddr (fetch_addr_s),
        .rdata (res_rd_s)
    );

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= LOAD;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state decode
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            LOAD: begin
                if (ld_acc_s && ld_last_s) state_nx_s = SERVE;
                else                       state_nx_s = LOAD;
            end
            SERVE: begin
                if (finish) state_nx_s = DUMP;
                else        state_nx_s = SERVE;
            end
            DUMP: begin
                if (dump_last_s) state_nx_s = DONE;
                else             state_nx_s = DUMP;
            end
            DONE:    state_nx_s = DONE;
            default: state_nx_s = LOAD;
        endcase
    end

    // Load pointer, status flags, result counter and the registered dump beat
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ld_ptr_r     <= ADDR_ZERO;
            gray_ready_r <= 1'b0;
            out_valid_r  <= 1'b0;
            out_addr_r   <= ADDR_ZERO;
            out_data_r   <= PIX_ZERO;
            wr_cnt_r     <= ADDR_ZERO;
            proto_err_r  <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (ld_acc_s) begin
                ld_ptr_r <= ld_ptr_r + ADDR_ONE;
            end
            if (ld_acc_s && ld_last_s) begin
                gray_ready_r <= 1'b1;
            end else if ((state_r == SERVE) && finish) begin
                gray_ready_r <= 1'b0;
            end
            if (res_we_s && (wr_cnt_r != ADDR_LAST)) begin
                wr_cnt_r <= wr_cnt_r + ADDR_ONE;
            end
            if (lbp_bad_s) begin
                proto_err_r <= 1'b1;
            end
            if (fetch_s) begin
                out_valid_r <= 1'b1;
                out_addr_r  <= fetch_addr_s;
                out_data_r  <= is_border(fetch_addr_s) ? PIX_ZERO : res_rd_s;
            end else if (dump_last_s) begin
                out_valid_r <= 1'b0;
                done_r      <= 1'b1;
            end
        end
    end

    assign ld_ready   = (state_r == LOAD);
    assign gray_ready = gray_ready_r;
    assign gray_data  = ((state_r == SERVE) && gray_req) ? gray_rd_s : PIX_ZERO;
    assign out_valid  = out_valid_r;
    assign out_addr   = out_addr_r;
    assign out_data   = out_data_r;
    assign wr_cnt     = wr_cnt_r;
    assign proto_err  = proto_err_r;
    assign done       = done_r;

endmodule

// File: tb/tb_lbp_host.sv
// Self-checking bench for lbp_host: gray read table, result capture corners and
// scoreboarded dumps (random backpressure, full completion, reset mid-dump).
module tb_lbp_host;

    localparam int N = 16384;

    logic        clk = 1'b0;
    logic        reset;
    logic        ld_valid;
    logic [7:0]  ld_data;
    logic        ld_ready;
    logic        gray_ready;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic        out_valid;
    logic        out_ready;
    logic [13:0] out_addr;
    logic [7:0]  out_data;
    logic [13:0] wr_cnt;
    logic        proto_err;
    logic        done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        req;
        logic [13:0] addr;
        logic [7:0]  exp;
    } gvec_t;

    typedef struct {
        logic [13:0] addr;
        logic [7:0]  data;
    } beat_t;

    logic [7:0] exp_res [0:N-1];
    beat_t      sb [$];
    gvec_t      gtab [8];

    lbp_host dut (
        .clk        (clk),
        .reset      (reset),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_addr   (out_addr),
        .out_data   (out_data),
        .wr_cnt     (wr_cnt),
        .proto_err  (proto_err),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit border(input int a);
        int r;
        int c;
        r = a / 128;
        c = a % 128;
        return (r == 0) || (r == 127) || (c == 0) || (c == 127);
    endfunction

    function automatic logic [7:0] pat(input int a);
        return 8'(((a * 7) ^ (a >> 6)) + 3);
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ld_ready"},   ld_ready,   1);
        chk({tag, "_gray_ready"}, gray_ready, 0);
        chk({tag, "_out_valid"},  out_valid,  0);
        chk({tag, "_out_addr"},   out_addr,   0);
        chk({tag, "_out_data"},   out_data,   0);
        chk({tag, "_wr_cnt"},     wr_cnt,     0);
        chk({tag, "_proto_err"},  proto_err,  0);
        chk({tag, "_done"},       done,       0);
    endtask

    task automatic fill_scoreboard();
        beat_t b;
        sb.delete();
        for (int a = 0; a < N; a++) begin
            b.addr = 14'(a);
            b.data = border(a) ? 8'h00 : exp_res[a];
            sb.push_back(b);
        end
    endtask

    // Drives out_ready and pops the scoreboard on each accepted beat; stop_at<0 runs to done.
    task automatic run_dump(input int rand_limit, input int stop_at,
                            output int acc, output int bzero, output int bubbles,
                            output bit stopped, output bit timed_out);
        bit          held;
        bit          seen;
        logic [13:0] h_addr;
        logic [7:0]  h_data;
        beat_t       e;
        int          cyc;
        acc = 0; bzero = 0; bubbles = 0; stopped = 0; timed_out = 1;
        held = 0; seen = 0; cyc = 0; h_addr = '0; h_data = '0;
        while (cyc < 40000) begin
            @(negedge clk);
            cyc++;
            if (held) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_addr", out_addr, h_addr);
                chk("hold_data", out_data, h_data);
            end
            chk("done_timing", done, (acc == N) ? 1 : 0);
            if (done || acc == N) begin
                timed_out = 0;
                break;
            end
            if (stop_at >= 0 && out_valid && out_addr == 14'(stop_at)) begin
                stopped = 1;
                timed_out = 0;
                break;
            end
            if (seen && !out_valid) bubbles++;
            if (out_valid) seen = 1;
            out_ready = (out_valid && int'(out_addr) < rand_limit) ? 1'($urandom_range(0, 1)) : 1'b1;
            held = out_valid && !out_ready;
            h_addr = out_addr;
            h_data = out_data;
            if (out_valid && out_ready) begin
                acc++;
                if (sb.size() == 0) begin
                    chk("sb_underflow", 1, 0);
                end else begin
                    e = sb.pop_front();
                    chk("dump_addr", out_addr, e.addr);
                    chk("dump_data", out_data, e.data);
                end
                if (border(int'(out_addr)) && out_data == 8'h00) bzero++;
            end
        end
    endtask

    initial begin
        int  ptr;
        int  acc;
        int  bzero;
        int  bubbles;
        bit  stopped;
        bit  timed_out;
        int  exp_cnt;

        reset = 1'b0; ld_valid = 0; ld_data = '0; gray_req = 0; gray_addr = '0;
        lbp_valid = 0; lbp_addr = '0; lbp_data = '0; finish = 0; out_ready = 0;
        for (int a = 0; a < N; a++) exp_res[a] = 8'h00;

        gtab[0] = '{1'b1, 14'd300,   8'h2C};
        gtab[1] = '{1'b1, 14'd16383, 8'hFF};
        gtab[2] = '{1'b1, 14'd0,     8'h00};
        gtab[3] = '{1'b0, 14'd300,   8'h00};
        gtab[4] = '{1'b1, 14'd129,   8'h81};
        gtab[5] = '{1'b1, 14'd1000,  8'hE8};
        gtab[6] = '{1'b1, 14'd8191,  8'hFF};
        gtab[7] = '{1'b1, 14'd127,   8'h7F};

        repeat (3) @(negedge clk);
        check_reset_vals("rst0");
        reset = 1'b1;

        // Ramp load with ld_valid every other cycle.
        ptr = 0;
        for (int k = 0; k < 2 * N; k++) begin
            @(negedge clk);
            if (k % 2 == 0) begin
                if (k == 2 * N - 2) chk("gray_ready_before_last", gray_ready, 0);
                ld_valid = 1'b1;
                ld_data  = 8'(ptr);
                if (ld_ready) ptr++;
            end else begin
                ld_valid = 1'b0;
            end
        end
        chk("load_accepted", ptr, N);
        chk("gray_ready_after_load", gray_ready, 1);
        chk("ld_ready_serve", ld_ready, 0);

        // Stray load beat in SERVE must not touch gray_mem[0].
        ld_valid = 1'b1; ld_data = 8'h77;
        @(negedge clk);
        ld_valid = 1'b0;

        for (int i = 0; i < 8; i++) begin
            gray_req  = gtab[i].req;
            gray_addr = gtab[i].addr;
            #1;
            chk($sformatf("gray_rd_%0d", gtab[i].addr), gray_data, gtab[i].exp);
            @(negedge clk);
        end
        gray_req = 0;

        lbp_valid = 1; lbp_addr = 14'd129; lbp_data = 8'hA5; exp_res[129] = 8'hA5;
        @(negedge clk);
        chk("wr_cnt_first", wr_cnt, 1);
        chk("proto_err_clean", proto_err, 0);
        lbp_addr = 14'd0; lbp_data = 8'h11;
        @(negedge clk);
        chk("proto_err_border", proto_err, 1);
        chk("wr_cnt_border", wr_cnt, 1);

        exp_cnt = 1;
        for (int a = 0; a < N; a++) begin
            if (!border(a)) begin
                lbp_addr = 14'(a); lbp_data = pat(a); exp_res[a] = pat(a);
                exp_cnt++;
                @(negedge clk);
            end
        end
        chk("wr_cnt_engine", wr_cnt, exp_cnt);
        lbp_addr = 14'd129; lbp_data = 8'hA5; exp_res[129] = 8'hA5; exp_cnt++;
        @(negedge clk);

        finish = 1; lbp_addr = 14'd130; lbp_data = 8'h3C; exp_res[130] = 8'h3C; exp_cnt++;
        fill_scoreboard();
        @(negedge clk);
        finish = 0;
        chk("wr_cnt_finish_cycle", wr_cnt, exp_cnt);
        chk("gray_ready_dump", gray_ready, 0);
        chk("out_valid_dump_entry", out_valid, 0);
        gray_req = 1; gray_addr = 14'd300;
        #1;
        chk("gray_data_dump", gray_data, 0);
        gray_req = 0;
        lbp_addr = 14'd131; lbp_data = 8'hEE;
        @(negedge clk);
        lbp_valid = 0;
        chk("first_beat_valid", out_valid, 1);

        run_dump(3000, -1, acc, bzero, bubbles, stopped, timed_out);
        chk("dump1_timeout", timed_out, 0);
        chk("dump1_accepted", acc, N);
        chk("dump1_border_zero", bzero, 508);
        chk("dump1_sb_empty", sb.size(), 0);
        chk("dump1_done", done, 1);
        chk("dump1_out_valid", out_valid, 0);
        chk("wr_cnt_after_dump", wr_cnt, exp_cnt);

        // DONE ignores everything.
        finish = 1; ld_valid = 1; lbp_valid = 1; lbp_addr = 14'd200;
        repeat (2) @(negedge clk);
        finish = 0; ld_valid = 0; lbp_valid = 0;
        chk("done_sticky", done, 1);
        chk("done_out_valid", out_valid, 0);
        chk("done_ld_ready", ld_ready, 0);
        chk("done_wr_cnt", wr_cnt, exp_cnt);

        reset = 1'b0;
        #1;
        check_reset_vals("rst1");
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            ld_valid = 1'b1;
            ld_data  = ~8'(k);
        end
        @(negedge clk);
        ld_valid = 1'b0;
        chk("gray_ready_reload", gray_ready, 1);
        gray_req = 1; gray_addr = 14'd300;
        #1;
        chk("gray_rd_inv_300", gray_data, 8'hD3);
        gray_addr = 14'd129;
        #1;
        chk("gray_rd_inv_129", gray_data, 8'h7E);
        gray_req = 0;

        finish = 1;
        fill_scoreboard();
        @(negedge clk);
        finish = 0;
        run_dump(0, 5000, acc, bzero, bubbles, stopped, timed_out);
        chk("dump2_reached_5000", stopped, 1);
        chk("dump2_accepted", acc, 5000);
        chk("dump2_bubbles", bubbles, 0);

        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_gray_ready", gray_ready, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_ld_ready", ld_ready, 1);
        chk("mid_rst_wr_cnt", wr_cnt, 0);
        chk("mid_rst_out_addr", out_addr, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ld_ready", ld_ready, 1);
        chk("post_rst_out_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
